pipeline_trace_buffer: RTL

//  Synthesizable retire-trace recorder for the RV32I pipeline.
//  - Snoops the MEM/WB writeback stage and stores one record per retired instruction: PC, instruction, rd, write-back data.
//  - Records go into a circular buffer of DEPTH entries.
//  - Stops POST_TRIG records after a halt-opcode trigger, then drains oldest-first over a valid/ready port.
//  - Replaces per-cycle simulation printing with a hardware trace usable in sim and on FPGA.

---
 rtl/pipeline_trace_buffer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipeline_trace_buffer.sv
// Retire-trace recorder: circular capture of MEM/WB records, trigger on halt opcode, oldest-first drain.
// Optional build macro TRACE_SKIP_X0_EN: drop retires that write no register (the halt trigger is always kept).
module pipeline_trace_buffer #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned POST_TRIG   = 4,
  parameter logic [6:0]  HALT_OPCODE = 7'b1111111
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     arm,
  input  logic                     wb_valid,
  input  logic [XLEN-1:0]          wb_pc,
  input  logic [31:0]              wb_instr,
  input  logic [4:0]               wb_rd,
  input  logic                     wb_reg_wr,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [XLEN-1:0]          rd_pc,
  output logic [31:0]              rd_instr,
  output logic [4:0]               rd_rd,
  output logic [XLEN-1:0]          rd_data,
  output logic                     rd_last,
  output logic [1:0]               state_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = XLEN + 32 + 5 + XLEN;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DUMP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] post_q, post_d;
  logic          overflow_q, overflow_d;
  logic [RW-1:0] mem_q [DEPTH];
  logic [RW-1:0] head;

  logic is_halt;
  logic keep;
  logic capture;
  logic pop;

  assign is_halt = (wb_instr[6:0] == HALT_OPCODE);

`ifdef TRACE_SKIP_X0_EN
  // Halt must survive filtering so the trigger can never be skipped.
  assign keep = (wb_reg_wr && (wb_rd != 5'd0)) || (state_q == S_ARMED && is_halt);
`else
  logic unused_reg_wr;
  assign unused_reg_wr = wb_reg_wr;
  assign keep          = 1'b1;
`endif

  assign capture  = enable && wb_valid && keep &&
                    (state_q == S_ARMED || state_q == S_POST);
  assign rd_valid = (state_q == S_DUMP) && (count_q != '0);
  assign pop      = rd_valid && rd_ready;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_d     = post_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d    = S_ARMED;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      S_ARMED, S_POST: begin
        if (capture) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (count_q == CW'(DEPTH)) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
          if (state_q == S_ARMED) begin
            if (is_halt) begin
              if (POST_TRIG != 0) begin
                state_d = S_POST;
                post_d  = CW'(POST_TRIG);
              end else begin
                state_d = S_DUMP;
              end
            end
          end else begin
            post_d = post_q - 1'b1;
            if (post_q == CW'(1)) state_d = S_DUMP;
          end
        end
      end
      default: begin
        if (pop) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
          if (count_q == CW'(1)) state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && capture) mem_q[wr_ptr_q] <= {wb_pc, wb_instr, wb_rd, wb_data};
  end

  assign head = mem_q[rd_ptr_q];
  assign {rd_pc, rd_instr, rd_rd, rd_data} = rd_valid ? head : '0;
  assign rd_last    = rd_valid && (count_q == CW'(1));
  assign state_o    = state_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
